// File: rtl/disp_pkg.sv
// Shared types and segment constants for the hit counter display.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package disp_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } dig_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high seven-segment pattern.
// Non-decimal codes light nothing.
module seg7_decode
  import disp_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hit_counter_display.sv
// Counts found rising edges in BCD and scans two 7-seg digits.
// Define HIT_SATURATE_EN to hold at 99 instead of wrapping.
module hit_counter_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       found,
  input  logic       clear,
  output logic       hit_pulse,
  output logic [7:0] count_bcd,
  output logic       ovf,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic POL_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_RST = POL_LOW ? ~SEG_0 : SEG_0;
  localparam logic [1:0] AN_RST  = POL_LOW ? 2'b10 : 2'b01;

  logic          r_s1, r_s2, r_s3;
  logic          r_hit;
  bcd_t          r_ones, r_tens;
  logic          r_ovf;
  logic [CW-1:0] r_scan;
  dig_t          r_state;
  dig_t          w_state_nxt;
  logic [1:0]    r_an;
  logic [6:0]    r_seg;
  logic          w_hit;
  logic          w_tc;
  bcd_t          w_digit;
  logic [6:0]    w_seg_ah;
  logic [1:0]    w_an_ah;

  assign w_hit = r_s2 & ~r_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      r_s1  <= found;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_hit <= w_hit;
    end
  end

  // clear beats a simultaneous hit; the pulse still reports the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_ovf  <= 1'b0;
    end else if (w_hit) begin
      if (r_tens == 4'd9 && r_ones == 4'd9) begin
        r_ovf <= 1'b1;
`ifdef HIT_SATURATE_EN
        r_ones <= 4'd9;
        r_tens <= 4'd9;
`else
        r_ones <= 4'd0;
        r_tens <= 4'd0;
`endif
      end else if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign w_tc = (r_scan == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan  <= '0;
      r_state <= DIG0;
    end else begin
      r_scan  <= w_tc ? '0 : r_scan + 1'b1;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tc) begin
      w_state_nxt = (r_state == DIG0) ? DIG1 : DIG0;
    end
  end

  // Outputs follow the next state so an and seg switch on one edge
  assign w_digit = (w_state_nxt == DIG0) ? r_ones : r_tens;
  assign w_an_ah = (w_state_nxt == DIG0) ? 2'b01 : 2'b10;

  seg7_decode u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_ah)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= AN_RST;
      r_seg <= SEG_RST;
    end else begin
      r_an  <= POL_LOW ? ~w_an_ah : w_an_ah;
      r_seg <= POL_LOW ? ~w_seg_ah : w_seg_ah;
    end
  end

  assign hit_pulse = r_hit;
  assign count_bcd = {r_tens, r_ones};
  assign ovf       = r_ovf;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_hit_counter_display.sv
// Directed bench for hit_counter_display, SCAN_DIV=4, active-low.
// Build with +define+HIT_SATURATE_EN to check the saturating variant.
module tb_hit_counter_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       found;
  logic       clear;
  logic       hit_pulse;
  logic [7:0] count_bcd;
  logic       ovf;
  logic [1:0] an;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;
  int npulse;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S9 = 7'h10;

  hit_counter_display #(
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .found     (found),
    .clear     (clear),
    .hit_pulse (hit_pulse),
    .count_bcd (count_bcd),
    .ovf       (ovf),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      found = 1'b1;
      step(3);
      found = 1'b0;
      step(3);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic wait_an(input logic [1:0] t);
    for (int i = 0; i < 12 && an !== t; i++) step(1);
    check("wait_an", {30'd0, an}, {30'd0, t});
  endtask

  initial begin
    reset = 1'b1;
    found = 1'b0;
    clear = 1'b0;
    step(2);
    check("rst_count", count_bcd, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    check("rst_hit", hit_pulse, 1'b0);
    check("rst_an", an, AN_ONES);
    check("rst_seg", seg, S0);

    reset = 1'b0;
    step(3);
    check("scan_an_e3", an, AN_ONES);
    step(1);
    check("scan_an_e4", an, AN_TENS);
    check("scan_seg_tens0", seg, S0);
    step(3);
    check("scan_an_e7", an, AN_TENS);
    step(1);
    check("scan_an_e8", an, AN_ONES);

    found = 1'b1;
    step(2);
    check("hit_e2", hit_pulse, 1'b0);
    check("cnt_e2", count_bcd, 8'h00);
    step(1);
    check("hit_e3", hit_pulse, 1'b1);
    check("cnt_e3", count_bcd, 8'h01);
    npulse = 0;
    for (int i = 0; i < 17; i++) begin
      step(1);
      if (hit_pulse) npulse++;
    end
    check("long_found_pulses", npulse, 0);
    found = 1'b0;
    step(3);
    check("cnt_after_long", count_bcd, 8'h01);

    do_clear();
    check("clear_cnt", count_bcd, 8'h00);
    pulse(10);
    check("cnt_10", count_bcd, 8'h10);
    wait_an(AN_TENS);
    check("seg_tens_1", seg, S1);
    wait_an(AN_ONES);
    check("seg_ones_0", seg, S0);

    do_clear();
    pulse(99);
    check("cnt_99", count_bcd, 8'h99);
    check("ovf_99", ovf, 1'b0);
    wait_an(AN_TENS);
    check("seg_tens_9", seg, S9);
    pulse(1);
    check("ovf_set", ovf, 1'b1);
`ifdef HIT_SATURATE_EN
    check("cnt_ovf", count_bcd, 8'h99);
`else
    check("cnt_ovf", count_bcd, 8'h00);
`endif
    pulse(1);
    check("ovf_sticky", ovf, 1'b1);
`ifdef HIT_SATURATE_EN
    check("cnt_post_ovf", count_bcd, 8'h99);
`else
    check("cnt_post_ovf", count_bcd, 8'h01);
`endif

    do_clear();
    check("clear_ovf", ovf, 1'b0);
    pulse(5);
    check("cnt_05", count_bcd, 8'h05);
    found = 1'b1;
    step(2);
    clear = 1'b1;
    step(1);
    check("clr_hit_pulse", hit_pulse, 1'b1);
    check("clr_hit_cnt", count_bcd, 8'h00);
    check("clr_hit_ovf", ovf, 1'b0);
    clear = 1'b0;
    found = 1'b0;
    step(3);
    check("clr_hit_after", count_bcd, 8'h00);

    pulse(42);
    check("cnt_42", count_bcd, 8'h42);
    found = 1'b1;
    step(2);
    reset = 1'b1;
    #2;
    check("async_rst_cnt", count_bcd, 8'h00);
    check("async_rst_an", an, AN_ONES);
    check("async_rst_seg", seg, S0);
    step(1);
    reset = 1'b0;
    step(2);
    check("rel_cnt_e2", count_bcd, 8'h00);
    check("rel_hit_e2", hit_pulse, 1'b0);
    step(1);
    check("rel_cnt_e3", count_bcd, 8'h01);
    check("rel_hit_e3", hit_pulse, 1'b1);
    step(1);
    check("rel_hit_e4", hit_pulse, 1'b0);
    step(5);
    check("rel_cnt_hold", count_bcd, 8'h01);
    found = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
